// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   DEPTH_DEFAULT     : number of 32-bit words in the data memory
//   ADDR_SSD/ADDR_DHT : memory-mapped I/O word addresses used by the peripherals
//   state_t           : arbiter transaction states
//   M0/M1             : requester (owner) identifiers
//   addr_in_range()   : address range check against a given depth
package mem_pkg;

    localparam int unsigned DEPTH_DEFAULT = 32'd1024;

    localparam logic [31:0] ADDR_SSD = 32'd1000;
    localparam logic [31:0] ADDR_DHT = 32'd1001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One requester port of the memory arbiter.
//   req/we/addr/wdata : request from the requester, req held until ack
//   ack/err/rdata     : one-cycle completion pulse, range error, registered read data
// master = requester side, slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way request picker.
//   req0_i/req1_i : requests
//   last_i        : owner of the previous transaction
//   rr_i          : 1 = round-robin on a tie, 0 = requester 0 always wins a tie
//   any_o         : at least one request is pending
//   winner_o      : selected requester (only meaningful while any_o is high)
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    input  logic rr_i,
    output logic any_o,
    output logic winner_o
);

    // Pick a winner; a tie under round-robin goes to whoever did not own the last transaction
    always_comb begin
        any_o    = req0_i | req1_i;
        winner_o = 1'b0;
        if (req0_i && req1_i) begin
            if (rr_i) begin
                winner_o = ~last_i;
            end else begin
                winner_o = 1'b0;
            end
        end else begin
            winner_o = req1_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data memory's write port and read port between two requesters.
// Each transaction is IDLE (latch request) -> ACCESS (drive memory) -> DONE (ack).
//   clk, rst          : clock, asynchronous active-high reset
//   m0, m1            : requester ports (req/we/addr/wdata in, ack/err/rdata out)
//   mem_write_enable  : memory write strobe, high only during ACCESS
//   mem_addr          : memory read/write address (last latched address)
//   mem_write_data    : memory write data
//   mem_read_data     : combinational memory read data for mem_addr
//   busy              : a transaction is in flight
//   grant             : owner of the current or last transaction
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned DATA_W = 32,
    parameter bit          RR     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave m0,
    mem_port_arbiter_if.slave m1,
    output logic              mem_write_enable,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy,
    output logic              grant
);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic                range_ok_q, range_ok_d;
    logic [31:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic                mem_we_q, mem_we_d;

    logic                pick_any, pick_winner;
    logic                sel_we;
    logic [31:0]         sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W-1:0]   rd_val;

    rr_pick2 u_pick (
        .req0_i   (m0.req),
        .req1_i   (m1.req),
        .last_i   (last_q),
        .rr_i     (RR),
        .any_o    (pick_any),
        .winner_o (pick_winner)
    );

    // Steer the winning requester's fields toward the request latch
    always_comb begin
        if (pick_winner == M1) begin
            sel_we    = m1.we;
            sel_addr  = m1.addr;
            sel_wdata = m1.wdata;
        end else begin
            sel_we    = m0.we;
            sel_addr  = m0.addr;
            sel_wdata = m0.wdata;
        end
    end

    // Out-of-range reads return zero instead of whatever the memory drives
    assign rd_val = range_ok_q ? mem_read_data : {DATA_W{1'b0}};

    // Transaction sequencing and datapath next-state
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        range_ok_d = range_ok_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
        mem_we_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d    = pick_winner;
                    we_d       = sel_we;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    range_ok_d = addr_in_range(sel_addr, DEPTH);
                    // Strobe is registered so it is high exactly for the ACCESS cycle
                    mem_we_d   = sel_we & range_ok_d;
                    state_d    = ACCESS;
                end else begin
                    state_d    = IDLE;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (owner_q == M1) begin
                        rdata1_d = rd_val;
                    end else begin
                        rdata0_d = rd_val;
                    end
                end else begin
                    rdata0_d = rdata0_q;
                end
                // Ack/err are registered here so they appear during DONE
                ack0_d  = (owner_q == M0);
                ack1_d  = (owner_q == M1);
                err0_d  = (owner_q == M0) && !range_ok_q;
                err1_d  = (owner_q == M1) && !range_ok_q;
                state_d = DONE;
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= M0;
            last_q     <= M1;
            we_q       <= 1'b0;
            range_ok_q <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= {DATA_W{1'b0}};
            rdata0_q   <= {DATA_W{1'b0}};
            rdata1_q   <= {DATA_W{1'b0}};
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            range_ok_q <= range_ok_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign m0.ack           = ack0_q;
    assign m0.err           = err0_q;
    assign m0.rdata         = rdata0_q;
    assign m1.ack           = ack1_q;
    assign m1.err           = err1_q;
    assign m1.rdata         = rdata1_q;
    assign mem_write_enable = mem_we_q;
    assign mem_addr         = addr_q;
    assign mem_write_data   = wdata_q;
    assign busy             = (state_q != IDLE);
    assign grant            = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// arbitration/reset sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_W(DW)) m0_if ();
    mem_port_arbiter_if #(.DATA_W(DW)) m1_if ();
    mem_port_arbiter_if #(.DATA_W(DW)) fp0_if ();
    mem_port_arbiter_if #(.DATA_W(DW)) fp1_if ();

    logic          mem_we, busy, grant;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;
    logic          fp_we, fp_busy, fp_grant;
    logic [31:0]   fp_addr;
    logic [DW-1:0] fp_wd, fp_rd;

    mem_port_arbiter #(.DEPTH(DEP), .DATA_W(DW), .RR(1'b1)) dut (
        .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
        .mem_write_enable(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_wd),
        .mem_read_data(mem_rd), .busy(busy), .grant(grant)
    );

    mem_port_arbiter #(.DEPTH(DEP), .DATA_W(DW), .RR(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .m0(fp0_if), .m1(fp1_if),
        .mem_write_enable(fp_we), .mem_addr(fp_addr), .mem_write_data(fp_wd),
        .mem_read_data(fp_rd), .busy(fp_busy), .grant(fp_grant)
    );

    // Initial memory contents, shared by the memory model and the reference model
    function automatic logic [31:0] pattern(input logic [31:0] a);
        if (a == ADDR_DHT) return 32'h0A1B_2C4D;
        return (a * 32'h0100_0193) ^ 32'h5A5A_0000;
    endfunction

    // Bench memory: combinational read, write on clock edge; garbage beyond DEPTH
    logic [DW-1:0] tb_mem [DEP];
    bit            tb_written [DEP];
    always @(posedge clk) begin
        if (mem_we && mem_addr < DEP) begin
            tb_mem[mem_addr[9:0]]     <= mem_wd;
            tb_written[mem_addr[9:0]] <= 1'b1;
        end
    end
    assign mem_rd = (mem_addr >= DEP) ? 32'hDEAD_BEEF :
                    (tb_written[mem_addr[9:0]] ? tb_mem[mem_addr[9:0]] : pattern(mem_addr));
    assign fp_rd  = ~fp_addr;

    // Reference model state
    logic [31:0] mm [DEP];
    bit          mv [DEP];
    logic [31:0] exp_rd0 = 32'd0, exp_rd1 = 32'd0;
    bit          last_m = 1'b1;
    bit          exp_grant = 1'b0;
    int          checks = 0, errors = 0;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a >= DEP) return 32'd0;
        if (mv[a[9:0]]) return mm[a[9:0]];
        return pattern(a);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (a < DEP) begin
            mm[a[9:0]] = d;
            mv[a[9:0]] = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit who, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (who) begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wd;
        end else begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wd;
        end
    endtask

    // One isolated transaction from a single requester, fully checked
    task automatic do_txn(input string tag, input bit who, input bit we,
                          input logic [31:0] addr, input logic [31:0] wd, input bit exp_err);
        int   lat;
        int   wecnt;
        logic got;
        logic eseen;
        drive(who, 1'b1, we, addr, wd);
        lat = 0; wecnt = 0; got = 1'b0; eseen = 1'b0;
        while (!got && lat < 6) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                chk({tag, "_maddr"}, mem_addr, addr);
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
                drive(who, 1'b1, ~we, ~addr, ~wd);
            end
            if (mem_we) begin
                wecnt++;
                chk({tag, "_wdata"}, mem_wd, wd);
            end
            chk({tag, "_other_ack"}, {31'd0, (who ? m0_if.ack : m1_if.ack)}, 32'd0);
            got   = who ? m1_if.ack : m0_if.ack;
            eseen = who ? m1_if.err : m0_if.err;
        end
        drive(who, 1'b0, 1'b0, 32'd0, 32'd0);
        chk({tag, "_latency"}, lat, 32'd2);
        chk({tag, "_ack"}, {31'd0, got}, 32'd1);
        chk({tag, "_err"}, {31'd0, eseen}, {31'd0, exp_err});
        if (!we) begin
            if (who) exp_rd1 = model_read(addr);
            else     exp_rd0 = model_read(addr);
        end else begin
            model_write(addr, wd);
        end
        chk({tag, "_rdata0"}, m0_if.rdata, exp_rd0);
        chk({tag, "_rdata1"}, m1_if.rdata, exp_rd1);
        chk({tag, "_wecnt"}, wecnt, (we && addr < DEP) ? 32'd1 : 32'd0);
        chk({tag, "_grant"}, {31'd0, grant}, {31'd0, who});
        last_m = who; exp_grant = who;
        @(posedge clk); #1;
        chk({tag, "_ack_pulse"}, {30'd0, m1_if.ack, m0_if.ack}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        bit          who;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          err;
        logic [31:0] rd;
    } vec_t;

    // Randomized requester state
    bit          act [2];
    logic        we_r [2];
    logic [31:0] ad_r [2];
    logic [31:0] wd_r [2];

    task automatic new_fields(input int r);
        we_r[r] = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 5))
            0:       ad_r[r] = 32'd1024 + $urandom_range(0, 5000);
            1:       ad_r[r] = $urandom;
            2:       ad_r[r] = $urandom_range(0, 1023);
            default: ad_r[r] = $urandom_range(0, 15);
        endcase
        wd_r[r] = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [9];
        int   d_it;
        int   idle_it;
        bit   own;
        logic        t_we;
        logic [31:0] t_addr, t_wd, t_rd;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        fp0_if.req = 1'b0; fp0_if.we = 1'b0; fp0_if.addr = 32'd30; fp0_if.wdata = 32'd0;
        fp1_if.req = 1'b0; fp1_if.we = 1'b0; fp1_if.addr = 32'd31; fp1_if.wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {28'd0, m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}, 32'd0);
        chk("rst_rdata0", m0_if.rdata, 32'd0);
        chk("rst_rdata1", m1_if.rdata, 32'd0);
        chk("rst_mem", {29'd0, mem_we, busy, grant}, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mwdata", mem_wd, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors: single requester, one transaction each
        vt[0] = '{M0, 1'b0, ADDR_DHT,      32'd0,          1'b0, 32'h0A1B_2C4D};
        vt[1] = '{M1, 1'b1, ADDR_SSD,      32'h0000_0005,  1'b0, 32'd0};
        vt[2] = '{M0, 1'b0, ADDR_SSD,      32'd0,          1'b0, 32'h0000_0005};
        vt[3] = '{M0, 1'b1, 32'd1024,      32'hFFFF_FFFF,  1'b1, 32'd0};
        vt[4] = '{M0, 1'b0, 32'd2000,      32'd0,          1'b1, 32'd0};
        vt[5] = '{M1, 1'b1, 32'd1023,      32'h1234_5678,  1'b0, 32'd0};
        vt[6] = '{M1, 1'b0, 32'd1023,      32'd0,          1'b0, 32'h1234_5678};
        vt[7] = '{M0, 1'b0, 32'd1024,      32'd0,          1'b1, 32'd0};
        vt[8] = '{M1, 1'b0, 32'd0,         32'd0,          1'b0, 32'h5A5A_0000};
        for (int i = 0; i < 9; i++) begin
            do_txn($sformatf("vec%0d", i), vt[i].who, vt[i].we, vt[i].addr, vt[i].wd, vt[i].err);
            if (!vt[i].we) begin
                chk($sformatf("vec%0d_table_rd", i), vt[i].who ? m1_if.rdata : m0_if.rdata, vt[i].rd);
            end
        end

        // Round-robin with both requesters holding req continuously
        begin
            int n0, n1, last_c;
            bit exp_w;
            n0 = 0; n1 = 0; last_c = -1; exp_w = ~last_m;
            drive(1'b0, 1'b1, 1'b0, 32'd10, 32'd0);
            drive(1'b1, 1'b1, 1'b0, 32'd20, 32'd0);
            for (int c = 1; c <= 12; c++) begin
                @(posedge clk); #1;
                chk("rr_onehot", {31'd0, m0_if.ack & m1_if.ack}, 32'd0);
                chk("rr_ack_slot", {31'd0, m0_if.ack | m1_if.ack}, (c % 3 == 2) ? 32'd1 : 32'd0);
                if (m0_if.ack || m1_if.ack) begin
                    chk("rr_owner", {31'd0, m1_if.ack}, {31'd0, exp_w});
                    if (last_c >= 0) chk("rr_spacing", c - last_c, 32'd3);
                    last_c = c;
                    if (m1_if.ack) begin
                        n1++; exp_rd1 = model_read(32'd20); last_m = 1'b1;
                    end else begin
                        n0++; exp_rd0 = model_read(32'd10); last_m = 1'b0;
                    end
                    chk("rr_rdata0", m0_if.rdata, exp_rd0);
                    chk("rr_rdata1", m1_if.rdata, exp_rd1);
                    exp_w = ~exp_w;
                end
            end
            drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            exp_grant = last_m;
            chk("rr_count0", n0, 32'd2);
            chk("rr_count1", n1, 32'd2);
        end

        // Fixed priority: m0 starves m1 until it drops req
        fp0_if.req = 1'b1;
        fp1_if.req = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            chk("fp_ack0", {31'd0, fp0_if.ack}, (c == 2 || c == 5 || c == 8) ? 32'd1 : 32'd0);
            chk("fp_ack1", {31'd0, fp1_if.ack}, (c == 11) ? 32'd1 : 32'd0);
            if (c == 2) chk("fp_rdata0", fp0_if.rdata, ~32'd30);
            if (c == 8) fp0_if.req = 1'b0;
            if (c == 11) begin
                chk("fp_rdata1", fp1_if.rdata, ~32'd31);
                fp1_if.req = 1'b0;
            end
        end

        // Reset asserted during ACCESS of an m1 write
        drive(1'b1, 1'b1, 1'b1, 32'd500, 32'hCAFE_F00D);
        @(posedge clk); #1;
        chk("rstmid_we_before", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_we_drop", {31'd0, mem_we}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_ack", {31'd0, m1_if.ack}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        exp_rd0 = 32'd0; exp_rd1 = 32'd0; last_m = 1'b1; exp_grant = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rstmid_no_ack", {30'd0, m1_if.ack, mem_we}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_idle", {30'd0, busy, m1_if.ack}, 32'd0);
        chk("rstmid_rdata1", m1_if.rdata, 32'd0);
        do_txn("rst_read_old", 1'b0, 1'b0, 32'd500, 32'd0, 1'b0);
        do_txn("rst_fresh_wr", 1'b1, 1'b1, 32'd500, 32'hCAFE_F00D, 1'b0);
        do_txn("rst_read_new", 1'b0, 1'b0, 32'd500, 32'd0, 1'b0);

        // Randomized traffic against a transaction-level timeline model
        act[0] = 1'b0; act[1] = 1'b0;
        d_it = -10; idle_it = 0; own = 1'b0;
        t_we = 1'b0; t_addr = 32'd0; t_wd = 32'd0; t_rd = 32'd0;
        for (int it = 0; it < 400; it++) begin
            bit in_acc, in_done;
            in_acc  = (it == d_it);
            in_done = (it == d_it + 1);
            if (in_done && !t_we) begin
                if (own) exp_rd1 = t_rd;
                else     exp_rd0 = t_rd;
            end
            if (in_acc) exp_grant = own;
            chk("rnd_ack0", {31'd0, m0_if.ack}, {31'd0, in_done && own == M0});
            chk("rnd_ack1", {31'd0, m1_if.ack}, {31'd0, in_done && own == M1});
            chk("rnd_err0", {31'd0, m0_if.err}, {31'd0, in_done && own == M0 && t_addr >= DEP});
            chk("rnd_err1", {31'd0, m1_if.err}, {31'd0, in_done && own == M1 && t_addr >= DEP});
            chk("rnd_rdata0", m0_if.rdata, exp_rd0);
            chk("rnd_rdata1", m1_if.rdata, exp_rd1);
            chk("rnd_busy", {31'd0, busy}, {31'd0, in_acc || in_done});
            chk("rnd_mem_we", {31'd0, mem_we}, {31'd0, in_acc && t_we && t_addr < DEP});
            chk("rnd_grant", {31'd0, grant}, {31'd0, exp_grant});
            if (in_acc) chk("rnd_maddr", mem_addr, t_addr);
            if (in_acc && t_we) chk("rnd_mwdata", mem_wd, t_wd);

            for (int r = 0; r < 2; r++) begin
                if (in_done && own == r[0]) begin
                    act[r] = ($urandom_range(0, 1) == 1);
                    if (act[r]) new_fields(r);
                end else if (in_acc && own == r[0]) begin
                    new_fields(r);
                end else if (!act[r]) begin
                    act[r] = ($urandom_range(0, 2) == 0);
                    if (act[r]) new_fields(r);
                end
            end
            drive(1'b0, act[0], we_r[0], ad_r[0], wd_r[0]);
            drive(1'b1, act[1], we_r[1], ad_r[1], wd_r[1]);

            if (it >= idle_it && (act[0] || act[1])) begin
                if (act[0] && act[1]) own = ~last_m;
                else                  own = act[1];
                t_we   = we_r[own];
                t_addr = ad_r[own];
                t_wd   = wd_r[own];
                t_rd   = model_read(t_addr);
                if (t_we) model_write(t_addr, t_wd);
                last_m  = own;
                d_it    = it + 1;
                idle_it = it + 3;
            end
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
